// File: rtl/fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage : PC generation, synchronous ROM request, IF/ID register with a
//               one-entry stall hold buffer and single-delay-slot jumps. rev 1.0
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        rom_en_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  output logic [31:0] id_addr_o,
  output logic [31:0] id_data_o,
  output logic        id_valid_o
);

  // id_valid_o uses inverted sense: 0 means the IF/ID word is live.
  localparam logic VALID   = 1'b0;
  localparam logic INVALID = 1'b1;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] pc;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        buf_valid;
  logic [31:0] buf_addr;
  logic [31:0] buf_data;
  logic        issue;
  logic        unused_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  assign issue      = (state == RUN) && !stall_i;
  assign rom_en_o   = issue;
  assign rom_addr_o = pc;

  // Jump targets are word aligned, so the low target bits are dropped.
  assign unused_ok  = ^jump_addr_i[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (issue) begin
      if (jump_en_i) begin
        pc <= {jump_addr_i[31:2], 2'b00};
      end else begin
        pc <= pc + 32'd4;
      end
    end
  end

  // A request issued alongside a sampled jump is the squashed branch+8 fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid <= 1'b0;
      req_addr  <= 32'h0;
    end else begin
      req_valid <= issue && !jump_en_i;
      req_addr  <= pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= 32'h0;
      buf_data  <= 32'h0;
    end else if (stall_i) begin
      if (req_valid) begin
        buf_valid <= 1'b1;
        buf_addr  <= req_addr;
        buf_data  <= rom_data_i;
      end
    end else begin
      buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_addr_o  <= 32'h0;
      id_data_o  <= 32'h0;
      id_valid_o <= INVALID;
    end else if (!stall_i) begin
      if (buf_valid) begin
        id_addr_o  <= buf_addr;
        id_data_o  <= buf_data;
        id_valid_o <= VALID;
      end else if (req_valid) begin
        id_addr_o  <= req_addr;
        id_data_o  <= rom_data_i;
        id_valid_o <= VALID;
      end else begin
        id_valid_o <= INVALID;
      end
    end
  end

  // No request issues during a stall, so an outstanding return and a held
  // word can never coexist.
  assert property (@(posedge clk) disable iff (rst) !(req_valid && buf_valid));

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// Testbench for fetch_stage: directed steps with a scoreboard of expected IF/ID contents.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        jump_en;
  logic [31:0] jump_addr;

  logic        rom_en_a, rom_en_b;
  logic [31:0] rom_addr_a, rom_addr_b;
  logic [31:0] rom_data_a, rom_data_b;
  logic [31:0] id_addr_a, id_addr_b;
  logic [31:0] id_data_a, id_data_b;
  logic        id_valid_a, id_valid_b;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        v;
    logic [31:0] a;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  always @(posedge clk) if (rom_en_a) rom_data_a <= rom_fn(rom_addr_a);
  always @(posedge clk) if (rom_en_b) rom_data_b <= rom_fn(rom_addr_b);

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .stall_i(stall), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
    .rom_en_o(rom_en_a), .rom_addr_o(rom_addr_a), .rom_data_i(rom_data_a),
    .id_addr_o(id_addr_a), .id_data_o(id_data_a), .id_valid_o(id_valid_a)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst(rst), .stall_i(1'b0), .jump_en_i(1'b0), .jump_addr_i(32'h0),
    .rom_en_o(rom_en_b), .rom_addr_o(rom_addr_b), .rom_data_i(rom_data_b),
    .id_addr_o(id_addr_b), .id_data_o(id_data_b), .id_valid_o(id_valid_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from a negedge: check the combinational request, queue the
  // expected IF/ID state after the edge, then compare it at the next negedge.
  task automatic step(input logic s, input logic j, input logic [31:0] ja,
                      input logic en, input logic [31:0] ra,
                      input logic v, input logic [31:0] ia);
    exp_t e;
    stall = s; jump_en = j; jump_addr = ja;
    #1;
    check("rom_en", {31'b0, rom_en_a}, {31'b0, en});
    check("rom_addr", rom_addr_a, ra);
    exp_q.push_back('{v: v, a: ia});
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check("id_valid", {31'b0, id_valid_a}, {31'b0, e.v});
    check("id_addr", id_addr_a, e.a);
    if (e.v == 1'b0) check("id_data", id_data_a, rom_fn(e.a));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jump_en = 1'b0; jump_addr = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_id_valid", {31'b0, id_valid_a}, 32'h1);
    check("rst_id_addr", id_addr_a, 32'h0);
    check("rst_id_data", id_data_a, 32'h0);
    check("rst_rom_en", {31'b0, rom_en_a}, 32'h0);
    rst = 1'b0;

    // Boot: BOOT cycle, issue, return; dut_b exercises PC wrap.
    step(0, 0, 0, 0, 32'h0, 1, 32'h0);
    check("b_pc0", rom_addr_b, 32'hFFFF_FFF8);
    step(0, 0, 0, 1, 32'h0, 1, 32'h0);
    check("b_pc1", rom_addr_b, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 32'h4, 0, 32'h0);
    check("b_pc2", rom_addr_b, 32'h0);
    check("b_id0_valid", {31'b0, id_valid_b}, 32'h0);
    check("b_id0_addr", id_addr_b, 32'hFFFF_FFF8);
    step(0, 0, 0, 1, 32'h8, 0, 32'h4);
    check("b_id1_addr", id_addr_b, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 32'hC, 0, 32'h8);
    check("b_id2_addr", id_addr_b, 32'h0);
    check("b_id2_data", id_data_b, rom_fn(32'h0));

    // Stall three cycles with 0x8 in ID; 0xC is held in the buffer.
    step(1, 0, 0, 0, 32'h10, 0, 32'h8);
    step(1, 0, 0, 0, 32'h10, 0, 32'h8);
    step(1, 0, 0, 0, 32'h10, 0, 32'h8);
    step(0, 0, 0, 1, 32'h10, 0, 32'hC);
    step(0, 0, 0, 1, 32'h14, 0, 32'h10);
    step(0, 0, 0, 1, 32'h18, 0, 32'h14);

    // Jump from 0x14 to 0xF8 to reach branch at 0x100.
    step(0, 1, 32'hF8, 1, 32'h1C, 0, 32'h18);
    step(0, 0, 0, 1, 32'hF8, 1, 32'h18);
    step(0, 0, 0, 1, 32'hFC, 0, 32'hF8);
    step(0, 0, 0, 1, 32'h100, 0, 32'hFC);
    step(0, 0, 0, 1, 32'h104, 0, 32'h100);

    // Branch at 0x100 -> 0x400: delay slot 0x104, bubble, then target.
    step(0, 1, 32'h400, 1, 32'h108, 0, 32'h104);
    step(0, 0, 0, 1, 32'h400, 1, 32'h104);
    step(0, 0, 0, 1, 32'h404, 0, 32'h400);
    step(0, 0, 0, 1, 32'h408, 0, 32'h404);

    // Branch at 0x404 held across a 2-cycle stall, unaligned target 0x203.
    step(1, 1, 32'h203, 0, 32'h40C, 0, 32'h404);
    step(1, 1, 32'h203, 0, 32'h40C, 0, 32'h404);
    step(0, 1, 32'h203, 1, 32'h40C, 0, 32'h408);
    step(0, 0, 0, 1, 32'h200, 1, 32'h408);
    step(0, 0, 0, 1, 32'h204, 0, 32'h200);
    step(0, 0, 0, 1, 32'h208, 0, 32'h204);

    // Stall so 0x208 is buffered, then reset between clock edges.
    step(1, 0, 0, 0, 32'h20C, 0, 32'h204);
    stall = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_id_valid", {31'b0, id_valid_a}, 32'h1);
    check("async_id_addr", id_addr_a, 32'h0);
    check("async_id_data", id_data_a, 32'h0);
    check("async_rom_en", {31'b0, rom_en_a}, 32'h0);
    check("async_rom_addr", rom_addr_a, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Restart: the buffered 0x208 must not appear.
    step(0, 0, 0, 0, 32'h0, 1, 32'h0);
    step(0, 0, 0, 1, 32'h0, 1, 32'h0);
    step(0, 0, 0, 1, 32'h4, 0, 32'h0);
    step(0, 0, 0, 1, 32'h8, 0, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
